// File: rtl/apb_cmd_master.sv
// apb_cmd_master: single-outstanding command-to-APB requester with response handshake and access timeout
module apb_cmd_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    localparam bit       TO_EN   = TIMEOUT_CYCLES != 0;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    state_t     state, state_n;
    logic [7:0] wait_cnt;
    logic       timed_out;
    assign cmd_ready = state == IDLE;
    assign timed_out = TO_EN && wait_cnt == TO_LAST;
    // state register; reset abandons any transfer in flight
    always_ff @(posedge pclk) begin
        state <= preset ? IDLE : state_n;
    end
    // next-state decode; pready beats timeout in the last permitted cycle
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = cmd_valid ? SETUP : IDLE;
            SETUP:   state_n = ACCESS;
            ACCESS:  state_n = (pready || timed_out) ? RESP : ACCESS;
            RESP:    state_n = rsp_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end
    // registered APB and response outputs derived from the upcoming state
    always_ff @(posedge pclk) begin
        if (preset) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            psel      <= state_n == SETUP || state_n == ACCESS;
            penable   <= state_n == ACCESS;
            rsp_valid <= state_n == RESP;
            if (state == IDLE && cmd_valid) begin
                paddr    <= {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
                pwrite   <= cmd_write;
                pwdata   <= cmd_write ? cmd_wdata : '0;
                wait_cnt <= '0;
            end
            if (state == ACCESS) begin
                if (pready) begin
                    rsp_rdata   <= pwrite ? '0 : prdata;
                    rsp_timeout <= 1'b0;
                end else if (timed_out) begin
                    rsp_rdata   <= '0;
                    rsp_timeout <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: randomized and directed checks of apb_cmd_master against a memory reference model
module tb_apb_cmd_master;
    localparam int TO = 16;
    logic        pclk = 1'b0;
    logic        preset, cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] cmd_addr, cmd_wdata, rsp_rdata, paddr, pwdata, prdata;
    logic        psel, penable, pwrite, pready;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] slave_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    apb_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata), .pready(pready)
    );

    always #5 pclk = ~pclk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Issues one command from IDLE and plays an APB slave that inserts 'waits' wait states.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input int waits,
                        output int lat, output int acc, output int setups, output int viol,
                        output logic [31:0] rdata, output logic to,
                        output logic [31:0] s_addr, output logic [31:0] s_wdata, output logic s_write);
        logic pp;
        lat = -1; acc = 0; setups = 0; viol = 0;
        rdata = 'x; to = 'x; s_addr = 'x; s_wdata = 'x; s_write = 'x;
        pp = psel;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        for (int i = 1; i <= 300; i++) begin
            @(negedge pclk);
            cmd_valid = 1'b0;
            if (penable && !psel) viol++;
            if (psel && !penable) begin
                setups++;
                if (pp) viol++;
                s_addr = paddr; s_wdata = pwdata; s_write = pwrite;
            end
            if (psel && penable) begin
                acc++;
                if (!pp) viol++;
                if (paddr !== s_addr || pwdata !== s_wdata || pwrite !== s_write) viol++;
                pready = acc > waits;
                prdata = slave_mem.exists(paddr) ? slave_mem[paddr] : 32'h0;
                if (pready && pwrite) slave_mem[paddr] = pwdata;
            end else begin
                pready = 1'b0;
                prdata = $urandom;
            end
            if (rsp_valid) begin
                lat = i; rdata = rsp_rdata; to = rsp_timeout;
                rsp_ready = 1'b1;
                @(negedge pclk);
                rsp_ready = 1'b0;
                break;
            end
            pp = psel;
        end
    endtask

    task automatic test_reset();
        preset = 1'b1;
        repeat (3) @(negedge pclk);
        checks++; if ({psel, penable, pwrite, rsp_valid, rsp_timeout} !== 5'b0) begin errors++; $display("FAIL reset_ctrl got %b exp 00000", {psel, penable, pwrite, rsp_valid, rsp_timeout}); end
        checks++; if (paddr !== 32'h0) begin errors++; $display("FAIL reset_paddr got %h exp 0", paddr); end
        checks++; if (pwdata !== 32'h0) begin errors++; $display("FAIL reset_pwdata got %h exp 0", pwdata); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rsp_rdata); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
        preset = 1'b0;
        @(negedge pclk);
    endtask

    task automatic test_reset_mid_access();
        bit seen_access = 0;
        bit bad = 0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h30; cmd_wdata = 32'h0; pready = 1'b0;
        for (int i = 0; i < 10 && !seen_access; i++) begin
            @(negedge pclk);
            cmd_valid = 1'b0;
            seen_access = psel && penable;
        end
        checks++; if (!seen_access) begin errors++; $display("FAIL rst_mid_reach_access got 0 exp 1"); end
        @(negedge pclk);
        preset = 1'b1;
        @(negedge pclk);
        checks++; if ({psel, penable, rsp_valid} !== 3'b0) begin errors++; $display("FAIL rst_mid_drop got %b exp 000", {psel, penable, rsp_valid}); end
        preset = 1'b0;
        pready = 1'b1;
        repeat (6) begin
            @(negedge pclk);
            if (rsp_valid !== 1'b0 || psel !== 1'b0) bad = 1;
        end
        pready = 1'b0;
        checks++; if (bad) begin errors++; $display("FAIL rst_mid_no_rsp got activity exp none"); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_idle got %b exp 1", cmd_ready); end
    endtask

    task automatic test_write();
        int lat, acc, setups, viol;
        logic [31:0] rd, sa, sw;
        logic to, swr;
        xfer(1'b1, 32'h0000_0013, 32'hDEAD_BEEF, 0, lat, acc, setups, viol, rd, to, sa, sw, swr);
        checks++; if (sa !== 32'h10) begin errors++; $display("FAIL wr_paddr got %h exp 00000010", sa); end
        checks++; if (sw !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_pwdata got %h exp deadbeef", sw); end
        checks++; if (swr !== 1'b1) begin errors++; $display("FAIL wr_pwrite got %b exp 1", swr); end
        checks++; if (setups !== 1 || acc !== 1) begin errors++; $display("FAIL wr_phases got setup %0d access %0d exp 1 1", setups, acc); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency got %0d exp 3", lat); end
        checks++; if (rd !== 32'h0 || to !== 1'b0) begin errors++; $display("FAIL wr_rsp got %h/%b exp 0/0", rd, to); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL wr_protocol got %0d exp 0", viol); end
    endtask

    task automatic test_read_wait();
        int lat, acc, setups, viol;
        logic [31:0] rd, sa, sw;
        logic to, swr;
        slave_mem[32'h20] = 32'h1234_5678;
        xfer(1'b0, 32'h20, 32'hFFFF_FFFF, 3, lat, acc, setups, viol, rd, to, sa, sw, swr);
        checks++; if (acc !== 4) begin errors++; $display("FAIL rd_access_cycles got %0d exp 4", acc); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL rd_protocol got %0d exp 0", viol); end
        checks++; if (sa !== 32'h20 || swr !== 1'b0 || sw !== 32'h0) begin errors++; $display("FAIL rd_ctrl got %h/%b/%h exp 00000020/0/0", sa, swr, sw); end
        checks++; if (rd !== 32'h1234_5678 || to !== 1'b0) begin errors++; $display("FAIL rd_rsp got %h/%b exp 12345678/0", rd, to); end
        checks++; if (lat !== 6) begin errors++; $display("FAIL rd_latency got %0d exp 6", lat); end
    endtask

    task automatic test_timeout();
        int lat, acc, setups, viol;
        logic [31:0] rd, sa, sw;
        logic to, swr;
        slave_mem[32'h50] = 32'hCAFE_F00D;
        xfer(1'b0, 32'h50, 32'h0, 1000, lat, acc, setups, viol, rd, to, sa, sw, swr);
        checks++; if (acc !== TO) begin errors++; $display("FAIL to_access_cycles got %0d exp %0d", acc, TO); end
        checks++; if (rd !== 32'h0 || to !== 1'b1) begin errors++; $display("FAIL to_rsp got %h/%b exp 0/1", rd, to); end
        checks++; if (lat !== TO + 2) begin errors++; $display("FAIL to_latency got %0d exp %0d", lat, TO + 2); end
        xfer(1'b0, 32'h50, 32'h0, TO - 1, lat, acc, setups, viol, rd, to, sa, sw, swr);
        checks++; if (acc !== TO) begin errors++; $display("FAIL to_edge_access_cycles got %0d exp %0d", acc, TO); end
        checks++; if (rd !== 32'hCAFE_F00D || to !== 1'b0) begin errors++; $display("FAIL to_edge_rsp got %h/%b exp cafef00d/0", rd, to); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL to_edge_protocol got %0d exp 0", viol); end
    endtask

    task automatic test_backpressure();
        bit got = 0;
        bit bad = 0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'h5555_AAAA;
        pready = 1'b1; rsp_ready = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge pclk);
            got = rsp_valid;
        end
        checks++; if (!got) begin errors++; $display("FAIL bp_first_rsp got none exp rsp_valid"); end
        repeat (5) begin
            if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0 || cmd_ready !== 1'b0 || psel !== 1'b0) bad = 1;
            @(negedge pclk);
        end
        checks++; if (bad) begin errors++; $display("FAIL bp_hold got unstable exp rsp_valid=1 cmd_ready=0 psel=0"); end
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
        checks++; if ({rsp_valid, cmd_ready, psel} !== 3'b010) begin errors++; $display("FAIL bp_release got %b exp 010", {rsp_valid, cmd_ready, psel}); end
        @(negedge pclk);
        cmd_valid = 1'b0;
        checks++; if ({psel, penable} !== 2'b10) begin errors++; $display("FAIL bp_next_accept got %b exp 10", {psel, penable}); end
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge pclk);
            got = rsp_valid;
        end
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0; pready = 1'b0;
        checks++; if (!got) begin errors++; $display("FAIL bp_second_rsp got none exp rsp_valid"); end
    endtask

    task automatic test_back_to_back();
        int lat, acc, setups, viol, waits;
        logic [31:0] rd, sa, sw, a, d, word, exp_rd;
        logic to, swr, w;
        slave_mem.delete();
        ref_mem.delete();
        for (int n = 0; n < 8; n++) begin
            w = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 31));
            d = $urandom;
            waits = $urandom_range(0, 3);
            word = a & ~32'h3;
            exp_rd = w ? 32'h0 : (ref_mem.exists(word) ? ref_mem[word] : 32'h0);
            if (w) ref_mem[word] = d;
            checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp 1", n, cmd_ready); end
            xfer(w, a, d, waits, lat, acc, setups, viol, rd, to, sa, sw, swr);
            checks++; if (viol !== 0 || setups !== 1) begin errors++; $display("FAIL b2b_protocol[%0d] got viol %0d setups %0d exp 0 1", n, viol, setups); end
            checks++; if (sa !== word || swr !== w) begin errors++; $display("FAIL b2b_ctrl[%0d] got %h/%b exp %h/%b", n, sa, swr, word, w); end
            checks++; if (acc !== waits + 1 || lat !== waits + 3) begin errors++; $display("FAIL b2b_timing[%0d] got acc %0d lat %0d exp %0d %0d", n, acc, lat, waits + 1, waits + 3); end
            checks++; if (rd !== exp_rd || to !== 1'b0) begin errors++; $display("FAIL b2b_rsp[%0d] got %h/%b exp %h/0", n, rd, to, exp_rd); end
        end
    endtask

    initial begin
        preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; prdata = '0; pready = 1'b0;
        test_reset();
        test_write();
        test_read_wait();
        test_timeout();
        test_backpressure();
        test_reset_mid_access();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- Upstream APB requester that feeds the peripheral-side APB interface (psel/penable/pwrite/paddr/pwdata out; prdata/pready in).
- Converts single-beat commands from the subsystem control path (sequencer or CPU-side shim) into legal APB setup/access transfers.
- Returns read data or a timeout flag on a response handshake.
- Exactly one transfer is outstanding at a time.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr and paddr.
- DATA_WIDTH, 32, width of write/read data.
- TIMEOUT_CYCLES, 16, maximum ACCESS-phase cycles before abort; 0 disables timeout. Range 0..255.

Ports:
- pclk  input  1  clock, all logic on rising edge
- preset  input  1  synchronous reset, active-high
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted this cycle when cmd_valid=1
- cmd_write  input  1  1=write, 0=read
- cmd_addr  input  ADDR_WIDTH  byte address
- cmd_wdata  input  DATA_WIDTH  write data
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumed
- rsp_rdata  output  DATA_WIDTH  read data (0 for writes and timeouts)
- rsp_timeout  output  1  transfer aborted by timeout
- paddr  output  ADDR_WIDTH  APB address
- psel  output  1  APB select
- penable  output  1  APB enable
- pwrite  output  1  APB direction
- pwdata  output  DATA_WIDTH  APB write data
- prdata  input  DATA_WIDTH  APB read data
- pready  input  1  APB ready

Interface note:
- One clock (pclk). Reset is synchronous and active-high (preset).

Behaviour:
- Reset values, sampled at a pclk edge with preset=1: state=IDLE; psel=0, penable=0, pwrite=0, paddr=0, pwdata=0; rsp_valid=0, rsp_rdata=0, rsp_timeout=0; wait counter=0.
- Reset mid-transfer aborts immediately: APB is dropped the next cycle and no response is produced.
- All outputs are registered, except cmd_ready, which is decoded from state (cmd_ready = state==IDLE).
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid, latch the command into paddr (bits [1:0] forced to 0), pwrite, and pwdata (0 for reads). Go to SETUP.
  - SETUP (exactly 1 cycle): psel=1, penable=0. Go to ACCESS.
  - ACCESS: psel=1, penable=1; paddr/pwrite/pwdata held stable; wait counter counts ACCESS cycles from 0.
    - If pready=1: capture prdata into rsp_rdata for reads (0 for writes), set rsp_timeout=0, go to RESP.
    - Else if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: set rsp_rdata=0, rsp_timeout=1, go to RESP.
    - Else: increment the counter.
    - pready=1 in the final permitted cycle wins over timeout.
  - RESP: psel=0, penable=0; paddr/pwrite/pwdata keep their last values; rsp_valid=1 with rsp_rdata/rsp_timeout stable. Stay until rsp_ready=1, then go to IDLE with rsp_valid=0 next cycle.
- Latency:
  - Command accept to psel=1: 1 cycle.
  - Zero-wait transfer: rsp_valid asserts 3 cycles after the accept edge.
  - Minimum issue interval: 4 cycles (IDLE, SETUP, ACCESS, RESP).
- Handshake and sampling rules:
  - cmd_* are sampled only in IDLE.
  - cmd_valid while busy is ignored and must be held by the requester.
  - rsp_ready is ignored outside RESP.
  - pready/prdata are sampled only in ACCESS.
- Timeout:
  - Maximum ACCESS length is TIMEOUT_CYCLES cycles.
  - With TIMEOUT_CYCLES=0 the block waits indefinitely.
  - The counter is cleared on entry to SETUP.
- Simultaneous events:
  - rsp_ready together with a pending cmd_valid in RESP: the command is not accepted until the following IDLE cycle.

Test Plan:
- Reset → all outputs 0, cmd_ready=1. Assert preset during ACCESS of a read → psel/penable=0 next cycle and no rsp_valid.
- Write addr=0x0000_0013, wdata=0xDEAD_BEEF, pready tied 1 → paddr=0x10, pwdata=0xDEADBEEF, pwrite=1. SETUP 1 cycle then ACCESS 1 cycle. rsp_valid at accept+3 with rsp_rdata=0, rsp_timeout=0.
- Read addr=0x20, pready low 3 ACCESS cycles then high with prdata=0x1234_5678 → psel/penable/paddr stable for all 4 ACCESS cycles; rsp_rdata=0x12345678, rsp_timeout=0.
- TIMEOUT_CYCLES=16, read with pready held 0 → exactly 16 ACCESS cycles, then rsp_timeout=1, rsp_rdata=0. Repeat with pready rising on the 16th cycle → normal completion, rsp_timeout=0.
- Response backpressure: hold rsp_ready=0 for 5 cycles with cmd_valid=1 → rsp stable, cmd_ready=0, psel=0 throughout. Release → IDLE next cycle, next command accepted the cycle after.
- Back-to-back 8 random read/write commands against a responder with random 0-3 wait states → APB protocol checks pass (setup before enable, stable controls) and responses arrive in order matching a reference memory.
